// File: rtl/bnn_pkg.sv
// Shared types, per-layer size defaults and the activation threshold
// used by the binary-network layer sequencers.
package bnn_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } bnn_state_e;

  // Layer geometry of the digit-recognition pipeline
  localparam int unsigned L1_IN_WIDTH = 784;
  localparam int unsigned L1_N_OUT    = 512;
  localparam int unsigned L2_IN_WIDTH = 512;
  localparam int unsigned L2_N_OUT    = 64;
  localparam int unsigned L3_IN_WIDTH = 64;
  localparam int unsigned L3_N_OUT    = 10;

  // Neuron fires when twice the agreement count reaches the row width (ties fire)
  function automatic logic bnn_fire(input logic [31:0] cnt_x2, input logic [31:0] width);
    return (cnt_x2 >= width);
  endfunction

endpackage

// File: rtl/bnn_neuron_eval.sv
// Combinational binary neuron: XNOR of activation and weight row, popcount,
// then sign activation against half the row width.
module bnn_neuron_eval
  import bnn_pkg::*;
#(
  parameter  int unsigned IN_WIDTH = L2_IN_WIDTH,
  localparam int unsigned CNT_W    = $clog2(IN_WIDTH + 1)
) (
  input  logic [IN_WIDTH-1:0] i_act,
  input  logic [IN_WIDTH-1:0] i_weight,
  output logic                o_fire_c
);

  logic [IN_WIDTH-1:0] w_xnor;
  logic [CNT_W-1:0]    w_cnt;
  logic [CNT_W:0]      w_cnt_x2;
  logic [CNT_W:0]      w_thr;

  assign w_xnor = ~(i_act ^ i_weight);

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < int'(IN_WIDTH); i++) begin
      w_cnt = w_cnt + CNT_W'(w_xnor[i]);
    end
  end

  // Doubling by shift keeps the compare exact at CNT_W+1 bits
  assign w_cnt_x2 = {w_cnt, 1'b0};
  assign w_thr    = (CNT_W + 1)'(IN_WIDTH);
  assign o_fire_c = bnn_fire(32'(w_cnt_x2), 32'(w_thr));

endmodule

// File: rtl/bnn_layer_seq.sv
// Fully-connected binary layer sequencer: latches one activation vector,
// streams N_OUT weight rows from a 1-cycle synchronous ROM, packs results.
module bnn_layer_seq
  import bnn_pkg::*;
#(
  parameter  int unsigned IN_WIDTH = L2_IN_WIDTH,
  parameter  int unsigned N_OUT    = L2_N_OUT,
  localparam int unsigned ADDR_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic                w_en,
  output logic [ADDR_W-1:0]   w_addr,
  input  logic [IN_WIDTH-1:0] w_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_OUT-1:0]    out_data,
  output logic                busy
);

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(N_OUT - 1);

  bnn_state_e          r_state;
  bnn_state_e          w_state_nxt;
  logic [ADDR_W-1:0]   r_k;
  logic [ADDR_W-1:0]   w_k_nxt;
  logic                w_accept;
  logic [IN_WIDTH-1:0] r_act;
  logic                r_ev_vld;
  logic [ADDR_W-1:0]   r_ev_idx;
  logic                w_fire;
  logic                r_in_ready;
  logic                r_w_en;
  logic                r_out_valid;
  logic                r_busy;
  logic [N_OUT-1:0]    r_out_data;

  bnn_neuron_eval #(
    .IN_WIDTH (IN_WIDTH)
  ) u_eval (
    .i_act    (r_act),
    .i_weight (w_data),
    .o_fire_c (w_fire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and issue index
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
          w_k_nxt     = '0;
        end
      end
      S_RUN: begin
        if (r_k == LAST_K) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_k_nxt = r_k + ADDR_W'(1);
        end
      end
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs follow the next state; eval index trails issue by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k         <= '0;
      r_act       <= '0;
      r_ev_vld    <= 1'b0;
      r_ev_idx    <= '0;
      r_in_ready  <= 1'b1;
      r_w_en      <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_k         <= w_k_nxt;
      r_ev_vld    <= r_w_en;
      r_ev_idx    <= r_k;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_w_en      <= (w_state_nxt == S_RUN);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
      if (w_accept) begin
        r_act <= in_data;
      end
      for (int j = 0; j < int'(N_OUT); j++) begin
        if (r_ev_vld && (r_ev_idx == ADDR_W'(j))) begin
          r_out_data[j] <= w_fire;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign w_en      = r_w_en;
  assign w_addr    = r_k;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

endmodule
